// File: rtl/cn_pkg.sv
// Shared CN flip-flop encodings, FSM state type and excitation mapping.
// CN_EXCITE_TOGGLE_EN selects minimal-change (hold/toggle) encoding.
package cn_pkg;

  localparam logic [1:0] CN_HOLD = 2'b00;
  localparam logic [1:0] CN_RST  = 2'b01;
  localparam logic [1:0] CN_SET  = 2'b10;
  localparam logic [1:0] CN_TGL  = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} cn_state_e;

  // Returns {c,n} that moves a CN flip-flop currently at q_model to b.
  function automatic logic [1:0] cn_enc(input logic b, input logic q_model);
`ifdef CN_EXCITE_TOGGLE_EN
    return (b == q_model) ? CN_HOLD : CN_TGL;
`else
    return b ? CN_SET : CN_RST;
`endif
  endfunction

endpackage

// File: rtl/cn_fb_check.sv
// Feedback checker: delays the expected bit two stages to line up with q_fb
// and keeps a sticky mismatch flag until clr or reset.
module cn_fb_check (
  input  logic clk,
  input  logic rst,
  input  logic exp_bit,
  input  logic exp_vld,
  input  logic clr,
  input  logic q_fb,
  output logic err
);

  logic [1:0] bit_q;
  logic [1:0] vld_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q <= 2'b00;
      vld_q <= 2'b00;
      err_q <= 1'b0;
    end else if (clr) begin
      bit_q <= 2'b00;
      vld_q <= 2'b00;
      err_q <= 1'b0;
    end else begin
      bit_q <= {bit_q[0], exp_bit};
      vld_q <= {vld_q[0], exp_vld};
      if (vld_q[1] && (q_fb != bit_q[1])) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;

endmodule

// File: rtl/cn_ff.sv
// CN flip-flop: (0,0) hold, (0,1) reset, (1,0) set, (1,1) toggle.
module cn_ff
  import cn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic n,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      unique case ({c, n})
        CN_HOLD: q <= q;
        CN_RST:  q <= 1'b0;
        CN_SET:  q <= 1'b1;
        CN_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/cn_excite_gen.sv
// Serialises a target word LSB first into CN excitations and checks q feedback.
// CN_EXCITE_TOGGLE_EN (see cn_pkg) selects hold/toggle instead of set/reset drive.
module cn_excite_gen
  import cn_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             c,
  output logic             n,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  cn_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             qm_q, qm_d;
  logic [1:0]       cn_q, cn_d;
  logic             drn_q, drn_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = (state_q == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      qm_q    <= 1'b0;
      cn_q    <= CN_HOLD;
      drn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      qm_q    <= qm_d;
      cn_q    <= cn_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    qm_d    = qm_q;
    cn_d    = CN_HOLD;
    drn_d   = drn_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Bit under excitation is always at sreg_q[0]; the model tracks where q lands.
        cn_d   = cn_enc(sreg_q[0], qm_q);
        qm_d   = sreg_q[0];
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = DRAIN;
          drn_d   = 1'b0;
        end
      end
      DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  cn_fb_check u_fb_check (
    .clk     (clk),
    .rst     (rst),
    .exp_bit (sreg_q[0]),
    .exp_vld (state_q == SHIFT),
    .clr     (accept),
    .q_fb    (q_fb),
    .err     (err)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign c        = cn_q[1];
  assign n        = cn_q[0];
  assign done     = done_q;

endmodule

// File: tb/tb_cn_excite_gen.sv
// Scoreboard bench: cn_excite_gen driving cn_ff, q looped back (optionally forced to 0).
module tb_cn_excite_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       c, n, q, q_fb;
  logic       busy, done, err;
  logic       force_zero = 1'b0;

  int total = 0;
  int bad   = 0;
  int negcnt = 0;
  int acc_neg = 0;
  logic q_track;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] cn;
    logic        q0;
    bit          fz;
  } word_t;

  word_t sb[$];

  always #5 clk = ~clk;
  always @(negedge clk) negcnt++;

  assign q_fb = force_zero ? 1'b0 : q;

  cn_excite_gen #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .c        (c),
    .n        (n),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  cn_ff u_ff (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .n   (n),
    .q   (q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {c,n} per bit, pair i at bits [2i+1:2i].
  function automatic logic [15:0] model_cn(input logic [7:0] d, input logic q0);
    logic [15:0] r;
    logic        qq;
    r  = '0;
    qq = q0;
    for (int i = 0; i < 8; i++) begin
`ifdef CN_EXCITE_TOGGLE_EN
      r[2*i +: 2] = (d[i] == qq) ? 2'b00 : 2'b11;
`else
      r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
`endif
      qq = d[i];
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic push_word(input logic [7:0] d, input bit fz, input bit keep_valid);
    word_t w;
    int    t;
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", {31'b0, in_ready}, 1);
    w.data = d;
    w.cn   = model_cn(d, q_track);
    w.q0   = q_track;
    w.fz   = fz;
    sb.push_back(w);
    q_track = d[7];
    acc_neg = negcnt;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  initial begin : monitor
    word_t       cur;
    int          k;
    bit          in_word;
    logic [15:0] sh;
    in_word = 0;
    k = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_word    = 0;
        force_zero = 1'b0;
        chk("rst_done", {31'b0, done}, 0);
      end else if (!in_word) begin
        if (busy) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            cur        = sb.pop_front();
            in_word    = 1;
            k          = 0;
            force_zero = cur.fz;
          end
        end else begin
          chk("idle_done", {31'b0, done}, 0);
        end
      end else begin
        k++;
      end
      if (in_word) begin
        chk("busy", {31'b0, busy}, {31'b0, k < 10});
        chk("in_ready", {31'b0, in_ready}, {31'b0, k >= 10});
        chk("done", {31'b0, done}, {31'b0, k == 10});
        chk("err", {31'b0, err}, {31'b0, cur.fz && k >= 3});
        if (k >= 1 && k <= 8) begin
          sh = cur.cn >> (2 * (k - 1));
          chk("cn", {30'b0, c, n}, {30'b0, sh[1:0]});
        end else begin
          chk("cn_quiet", {30'b0, c, n}, 0);
        end
        if (k >= 2 && k <= 9) chk("q", {31'b0, q}, {31'b0, cur.data[k-2]});
        else if (k == 10) chk("q_last", {31'b0, q}, {31'b0, cur.data[7]});
        else chk("q_prev", {31'b0, q}, {31'b0, cur.q0});
        if (k == 10) begin
          in_word    = 0;
          force_zero = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    int t1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    q_track  = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cn", {30'b0, c, n}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst = 1'b1;
    @(negedge clk);

    push_word(8'h0F, 0, 0);
    push_word(8'hA5, 0, 0);
    push_word(8'hFF, 1, 0);

    // Valid held high across two words; second accept 11 cycles later.
    push_word(8'h01, 0, 1);
    t1 = acc_neg;
    push_word(8'h80, 0, 0);
    chk("b2b_gap", acc_neg - t1, 11);

    // Abort word 8'h3C just after edge T+4 and check the async reset response.
    push_word(8'h3C, 0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_cn", {30'b0, c, n}, 0);
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_err", {31'b0, err}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_q", {31'b0, q}, 0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    q_track = 1'b0;
    chk("abort_sb_flushed", sb.size(), 0);
    @(negedge clk);

    push_word(8'h5A, 0, 0);
    repeat (16) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
